// File: rtl/savestate_sequencer.sv
// savestate_sequencer: halts the core, launches one streamer
// transfer for a save/load slot, then releases the core.
`timescale 1ns/1ps
module savestate_sequencer #(
   parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
   parameter int          SLOT_BITS     = 2,
   parameter int          SLOT_SHIFT    = 20,
   parameter int          HALT_TIMEOUT  = 65535,
   parameter int          START_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_save,
   input  logic                 cmd_load,
   input  logic [SLOT_BITS-1:0] cmd_slot,
   output logic                 cmd_ready,
   output logic                 done,
   output logic [1:0]           status,
   output logic                 active,
   output logic                 halt_req,
   input  logic                 halt_ack,
   output logic [31:0]          ss_start_addr,
   output logic [31:0]          ss_length,
   output logic                 ss_read_start,
   output logic                 ss_write_start,
   input  logic                 ss_busy
);

   localparam int CNT_MAX = (HALT_TIMEOUT > START_TIMEOUT) ?
                            HALT_TIMEOUT : START_TIMEOUT;
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] HALT_LIM  = CW'(HALT_TIMEOUT);
   localparam logic [CW-1:0] START_LIM = CW'(START_TIMEOUT);
   localparam logic [31:0] SLOT_LEN = 32'd1 << SLOT_SHIFT;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_HALT_TO = 2'd1;
   localparam logic [1:0] ST_NOSTART = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT_WAIT,
      S_START,
      S_BUSY_WAIT,
      S_RUN,
      S_RELEASE,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    status_q, status_d;
   logic          save_q, save_d;
   logic [31:0]   addr_q, addr_d;
   logic          wr_q, wr_d;
   logic          rd_q, rd_d;

   logic          accept;
   logic [31:0]   slot_ext;

   assign accept   = cmd_save | cmd_load;
   assign slot_ext = 32'(cmd_slot);

   // State register; reset returns to IDLE at once, dropping halt_req.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: halt handshake, start, busy tracking, release.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_HALT_WAIT;
         end
         S_HALT_WAIT: begin
            if (halt_ack)               state_d = S_START;
            else if (cnt_q == HALT_LIM) state_d = S_RELEASE;
         end
         S_START: begin
            state_d = S_BUSY_WAIT;
         end
         S_BUSY_WAIT: begin
            if (ss_busy)                 state_d = S_RUN;
            else if (cnt_q == START_LIM) state_d = S_RELEASE;
         end
         S_RUN: begin
            if (!ss_busy) state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (!halt_ack) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: timers, status, slot window, start pulses.
   always_comb begin
      cnt_d    = cnt_q;
      status_d = status_q;
      save_d   = save_q;
      addr_d   = addr_q;
      wr_d     = 1'b0;
      rd_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               save_d = cmd_save;
               addr_d = BASE_ADDR + (slot_ext << SLOT_SHIFT);
               cnt_d  = '0;
            end
         end
         S_HALT_WAIT: begin
            if (!halt_ack) begin
               if (cnt_q == HALT_LIM) status_d = ST_HALT_TO;
               else                   cnt_d    = cnt_q + CW'(1);
            end
         end
         S_START: begin
            wr_d  = save_q;
            rd_d  = !save_q;
            cnt_d = '0;
         end
         S_BUSY_WAIT: begin
            if (!ss_busy) begin
               if (cnt_q == START_LIM) status_d = ST_NOSTART;
               else                    cnt_d    = cnt_q + CW'(1);
            end
         end
         S_RUN: begin
            if (!ss_busy) status_d = ST_OK;
         end
         default: ;
      endcase
   end

   // Datapath registers; start pulses clear asynchronously on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         status_q <= ST_OK;
         save_q   <= 1'b0;
         addr_q   <= BASE_ADDR;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         status_q <= status_d;
         save_q   <= save_d;
         addr_q   <= addr_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
      end
   end

   // Outputs decoded from state; halt_req spans accept to release.
   always_comb begin
      cmd_ready = (state_q == S_IDLE);
      active    = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      halt_req  = (state_q == S_HALT_WAIT) ||
                  (state_q == S_START)     ||
                  (state_q == S_BUSY_WAIT) ||
                  (state_q == S_RUN);
   end

   assign status         = status_q;
   assign ss_start_addr  = addr_q;
   assign ss_length      = SLOT_LEN;
   assign ss_write_start = wr_q;
   assign ss_read_start  = rd_q;

endmodule

// File: tb/tb_savestate_sequencer.sv
// tb_savestate_sequencer: core and streamer responders plus
// per-scenario tasks checked against a timeline model.
`timescale 1ns/1ps
module tb_savestate_sequencer;

   localparam logic [31:0] BASE    = 32'h3000_0000;
   localparam logic [31:0] SLOT_SZ = 32'h0010_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_save;
   logic        cmd_load;
   logic [1:0]  cmd_slot;
   logic        cmd_ready;
   logic        done;
   logic [1:0]  status;
   logic        active;
   logic        halt_req;
   logic        halt_ack;
   logic [31:0] ss_start_addr;
   logic [31:0] ss_length;
   logic        ss_read_start;
   logic        ss_write_start;
   logic        ss_busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int n_wr = 0, n_rd = 0, n_done = 0, n_hcyc = 0;
   int n_hrise = 0, n_bad_done = 0, done_cyc = 0;
   bit hr_prev = 1'b0;

   int ack_delay  = 0;
   bit ack_never  = 1'b0;
   int busy_delay = 0;
   int busy_len   = 1;
   bit busy_never = 1'b0;

   savestate_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cmd_save       (cmd_save),
      .cmd_load       (cmd_load),
      .cmd_slot       (cmd_slot),
      .cmd_ready      (cmd_ready),
      .done           (done),
      .status         (status),
      .active         (active),
      .halt_req       (halt_req),
      .halt_ack       (halt_ack),
      .ss_start_addr  (ss_start_addr),
      .ss_length      (ss_length),
      .ss_read_start  (ss_read_start),
      .ss_write_start (ss_write_start),
      .ss_busy        (ss_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: cumulative event counters sampled mid-cycle.
   always @(negedge clk) begin
      if (ss_write_start) n_wr++;
      if (ss_read_start) n_rd++;
      if (halt_req) n_hcyc++;
      if (halt_req && !hr_prev) n_hrise++;
      hr_prev = halt_req;
      if (done) begin
         n_done++;
         done_cyc = cyc;
         if (halt_req) n_bad_done++;
      end
   end

   // Core model: acks ack_delay cycles after halt_req, drops with it.
   initial begin
      int hcnt;
      hcnt = 0;
      halt_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n || !halt_req) begin
            halt_ack = 1'b0;
            hcnt = 0;
         end else if (!ack_never) begin
            if (hcnt >= ack_delay) halt_ack = 1'b1;
            else hcnt++;
         end
      end
   end

   // Streamer model: busy_delay cycles after a start, busy for busy_len.
   initial begin
      ss_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset_n && !busy_never &&
             (ss_write_start || ss_read_start)) begin
            repeat (busy_delay) @(posedge clk);
            #1 ss_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 ss_busy = 1'b0;
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog sim time exceeded");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] slot_addr(input int slot);
      return BASE + 32'(slot) * SLOT_SZ;
   endfunction

   task automatic issue(input bit sv, input bit ld,
                        input logic [1:0] slot,
                        output int acc, output bit tmo);
      tmo = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            tmo = 1'b0;
            break;
         end
      end
      cmd_save = sv;
      cmd_load = ld;
      cmd_slot = slot;
      @(posedge clk);
      #1;
      acc = cyc;
      cmd_save = 1'b0;
      cmd_load = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit tmo);
      int d0;
      d0 = n_done;
      tmo = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (n_done != d0) begin
            tmo = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cmd_save = 1'b0;
      cmd_load = 1'b0;
      cmd_slot = 2'd0;
      repeat (3) @(negedge clk);
      tests++;
      if ({cmd_ready, active, halt_req, done, ss_read_start,
           ss_write_start, status} !== 8'b1000_0000) begin
         fails++;
         $display("FAIL reset_flags got %b want 10000000",
                  {cmd_ready, active, halt_req, done,
                   ss_read_start, ss_write_start, status});
      end
      tests++;
      if (ss_start_addr !== BASE) begin
         fails++;
         $display("FAIL reset_addr got %h want %h", ss_start_addr, BASE);
      end
      tests++;
      if (ss_length !== SLOT_SZ) begin
         fails++;
         $display("FAIL reset_len got %h want %h", ss_length, SLOT_SZ);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if ({cmd_ready, active} !== 2'b10) begin
         fails++;
         $display("FAIL reset_idle got %b want 10", {cmd_ready, active});
      end
   endtask

   task automatic test_save();
      int acc, w0, r0, d0, b0, h0;
      bit t1, t2;
      ack_delay = 3; busy_delay = 0; busy_len = 40;
      w0 = n_wr; r0 = n_rd; d0 = n_done; b0 = n_bad_done; h0 = n_hrise;
      issue(1'b1, 1'b0, 2'd2, acc, t1);
      wait_done(200, t2);
      tests++;
      if (t1 || t2) begin
         fails++;
         $display("FAIL save_timeout got %b%b want 00", t1, t2);
      end
      tests++;
      if (ss_start_addr !== 32'h3020_0000) begin
         fails++;
         $display("FAIL save_addr got %h want 30200000", ss_start_addr);
      end
      tests++;
      if (ss_length !== 32'h0010_0000) begin
         fails++;
         $display("FAIL save_len got %h want 00100000", ss_length);
      end
      tests++;
      if ((n_wr - w0) != 1 || (n_rd - r0) != 0) begin
         fails++;
         $display("FAIL save_pulses got wr=%0d rd=%0d want 1 0",
                  n_wr - w0, n_rd - r0);
      end
      tests++;
      if (status !== 2'd0) begin
         fails++;
         $display("FAIL save_status got %0d want 0", status);
      end
      tests++;
      if ((n_bad_done - b0) != 0 || (n_hrise - h0) != 1) begin
         fails++;
         $display("FAIL save_halt got bad=%0d rise=%0d want 0 1",
                  n_bad_done - b0, n_hrise - h0);
      end
      tests++;
      if (done_cyc - acc != 47) begin
         fails++;
         $display("FAIL save_latency got %0d want 47", done_cyc - acc);
      end
      tests++;
      if (cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL save_ready_at_done got %b want 0", cmd_ready);
      end
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b1 || (n_done - d0) != 1) begin
         fails++;
         $display("FAIL save_ready_after got rdy=%b done=%0d want 1 1",
                  cmd_ready, n_done - d0);
      end
   endtask

   task automatic test_load();
      int acc, w0, r0, d0;
      bit t1, t2;
      ack_delay = 0; busy_delay = 2; busy_len = 5;
      w0 = n_wr; r0 = n_rd; d0 = n_done;
      issue(1'b0, 1'b1, 2'd3, acc, t1);
      wait_done(200, t2);
      tests++;
      if (t1 || t2 || ss_start_addr !== 32'h3030_0000) begin
         fails++;
         $display("FAIL load_addr got %h tmo=%b%b want 30300000",
                  ss_start_addr, t1, t2);
      end
      tests++;
      if ((n_rd - r0) != 1 || (n_wr - w0) != 0 || (n_done - d0) != 1) begin
         fails++;
         $display("FAIL load_pulses got rd=%0d wr=%0d dn=%0d want 1 0 1",
                  n_rd - r0, n_wr - w0, n_done - d0);
      end
      tests++;
      if (done_cyc - acc != 0 + 2 + 5 + 4 || status !== 2'd0) begin
         fails++;
         $display("FAIL load_latency got %0d st=%0d want 11 0",
                  done_cyc - acc, status);
      end
   endtask

   task automatic test_random();
      int acc, w0, r0, d0, h0, b0, slot, exp_lat;
      bit sv, t1, t2;
      for (int n = 0; n < 20; n++) begin
         sv = 1'($urandom_range(0, 1));
         slot = $urandom_range(0, 3);
         ack_delay = $urandom_range(0, 6);
         busy_delay = $urandom_range(0, 15);
         busy_len = $urandom_range(1, 25);
         exp_lat = ack_delay + busy_delay + busy_len + 4;
         w0 = n_wr; r0 = n_rd; d0 = n_done; h0 = n_hrise; b0 = n_bad_done;
         issue(sv, !sv, 2'(slot), acc, t1);
         wait_done(300, t2);
         tests++;
         if (t1 || t2 || ss_start_addr !== slot_addr(slot)) begin
            fails++;
            $display("FAIL rand%0d_addr got %h want %h tmo=%b%b",
                     n, ss_start_addr, slot_addr(slot), t1, t2);
         end
         tests++;
         if ((n_wr - w0) != int'(sv) || (n_rd - r0) != int'(!sv)) begin
            fails++;
            $display("FAIL rand%0d_dir got wr=%0d rd=%0d want save=%b",
                     n, n_wr - w0, n_rd - r0, sv);
         end
         tests++;
         if (done_cyc - acc != exp_lat || status !== 2'd0) begin
            fails++;
            $display("FAIL rand%0d_lat got %0d st=%0d want %0d 0",
                     n, done_cyc - acc, status, exp_lat);
         end
         tests++;
         if ((n_done - d0) != 1 || (n_hrise - h0) != 1 ||
             (n_bad_done - b0) != 0) begin
            fails++;
            $display("FAIL rand%0d_hs got dn=%0d rise=%0d bad=%0d want 1 1 0",
                     n, n_done - d0, n_hrise - h0, n_bad_done - b0);
         end
      end
   endtask

   task automatic test_both_and_ignored();
      int acc, w0, r0, d0;
      bit t1, t2, seen;
      ack_delay = 1; busy_delay = 0; busy_len = 30;
      w0 = n_wr; r0 = n_rd; d0 = n_done;
      issue(1'b1, 1'b1, 2'd1, acc, t1);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ss_busy && active) begin
            seen = 1'b1;
            break;
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cmd_load = 1'b1;
         cmd_save = 1'(i % 2);
         cmd_slot = 2'd0;
         @(negedge clk);
         cmd_load = 1'b0;
         cmd_save = 1'b0;
      end
      wait_done(200, t2);
      tests++;
      if (t1 || t2 || !seen) begin
         fails++;
         $display("FAIL both_progress got tmo=%b%b run=%b want 00 1",
                  t1, t2, seen);
      end
      tests++;
      if ((n_wr - w0) != 1 || (n_rd - r0) != 0) begin
         fails++;
         $display("FAIL both_dir got wr=%0d rd=%0d want 1 0",
                  n_wr - w0, n_rd - r0);
      end
      tests++;
      if (ss_start_addr !== slot_addr(1)) begin
         fails++;
         $display("FAIL both_addr got %h want %h",
                  ss_start_addr, slot_addr(1));
      end
      repeat (6) @(negedge clk);
      tests++;
      if ((n_done - d0) != 1 || active !== 1'b0) begin
         fails++;
         $display("FAIL ignored_cmds got dn=%0d act=%b want 1 0",
                  n_done - d0, active);
      end
   endtask

   task automatic test_busy_timeout();
      int acc, w0, r0, d0, hc0, b0;
      bit t1, t2;
      ack_delay = 0; busy_delay = 15; busy_len = 3; busy_never = 1'b0;
      issue(1'b1, 1'b0, 2'd0, acc, t1);
      wait_done(200, t2);
      tests++;
      if (t1 || t2 || status !== 2'd0 || done_cyc - acc != 22) begin
         fails++;
         $display("FAIL busy_edge got st=%0d lat=%0d tmo=%b%b want 0 22",
                  status, done_cyc - acc, t1, t2);
      end
      busy_never = 1'b1;
      w0 = n_wr; r0 = n_rd; d0 = n_done; hc0 = n_hcyc; b0 = n_bad_done;
      issue(1'b0, 1'b1, 2'd2, acc, t1);
      wait_done(200, t2);
      tests++;
      if (t1 || t2 || status !== 2'd2) begin
         fails++;
         $display("FAIL busy_to_status got %0d tmo=%b%b want 2",
                  status, t1, t2);
      end
      tests++;
      if ((n_hcyc - hc0) != 18 || (n_bad_done - b0) != 0) begin
         fails++;
         $display("FAIL busy_to_halt got hcyc=%0d bad=%0d want 18 0",
                  n_hcyc - hc0, n_bad_done - b0);
      end
      tests++;
      if ((n_rd - r0) != 1 || (n_wr - w0) != 0 || (n_done - d0) != 1) begin
         fails++;
         $display("FAIL busy_to_pulses got rd=%0d wr=%0d dn=%0d want 1 0 1",
                  n_rd - r0, n_wr - w0, n_done - d0);
      end
      busy_never = 1'b0;
      repeat (5) @(negedge clk);
      tests++;
      if (status !== 2'd2) begin
         fails++;
         $display("FAIL status_hold got %0d want 2", status);
      end
   endtask

   task automatic test_reset_mid_run();
      int acc;
      bit t1, seen;
      ack_delay = 0; busy_delay = 0; busy_len = 50;
      issue(1'b1, 1'b0, 2'd1, acc, t1);
      tests++;
      if (t1 || status !== 2'd2 || halt_req !== 1'b1) begin
         fails++;
         $display("FAIL accept_keeps_status got st=%0d hr=%b want 2 1",
                  status, halt_req);
      end
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ss_busy && halt_req) begin
            seen = 1'b1;
            break;
         end
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      tests++;
      if (!seen || {halt_req, active, ss_write_start, ss_read_start} !== 4'b0) begin
         fails++;
         $display("FAIL rst_async got %b run=%b want 0000 1",
                  {halt_req, active, ss_write_start, ss_read_start}, seen);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b1 || status !== 2'd0 || active !== 1'b0 ||
          ss_start_addr !== BASE) begin
         fails++;
         $display("FAIL rst_after got rdy=%b st=%0d act=%b a=%h want 1 0 0 %h",
                  cmd_ready, status, active, ss_start_addr, BASE);
      end
      for (int i = 0; i < 100 && ss_busy; i++) @(negedge clk);
      busy_len = 5;
      issue(1'b0, 1'b1, 2'd3, acc, t1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ss_read_start) begin
            seen = 1'b1;
            break;
         end
      end
      reset_n = 1'b0;
      #1;
      tests++;
      if (!seen || ss_read_start !== 1'b0 || halt_req !== 1'b0) begin
         fails++;
         $display("FAIL rst_pulse got rs=%b hr=%b seen=%b want 0 0 1",
                  ss_read_start, halt_req, seen);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 100 && ss_busy; i++) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_halt_timeout();
      int acc, w0, r0, d0, hc0, b0;
      bit t1, t2;
      ack_never = 1'b1;
      w0 = n_wr; r0 = n_rd; d0 = n_done; hc0 = n_hcyc; b0 = n_bad_done;
      issue(1'b1, 1'b0, 2'd0, acc, t1);
      wait_done(70000, t2);
      tests++;
      if (t1 || t2 || status !== 2'd1) begin
         fails++;
         $display("FAIL halt_to_status got %0d tmo=%b%b want 1",
                  status, t1, t2);
      end
      tests++;
      if ((n_hcyc - hc0) != 65536) begin
         fails++;
         $display("FAIL halt_to_cycles got %0d want 65536", n_hcyc - hc0);
      end
      tests++;
      if ((n_wr - w0) != 0 || (n_rd - r0) != 0 || (n_bad_done - b0) != 0) begin
         fails++;
         $display("FAIL halt_to_pulses got wr=%0d rd=%0d bad=%0d want 0 0 0",
                  n_wr - w0, n_rd - r0, n_bad_done - b0);
      end
      repeat (4) @(negedge clk);
      tests++;
      if ((n_done - d0) != 1 || cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL halt_to_done got dn=%0d rdy=%b want 1 1",
                  n_done - d0, cmd_ready);
      end
      ack_never = 1'b0;
   endtask

   initial begin
      test_reset();
      test_save();
      test_load();
      test_random();
      test_both_and_ignored();
      test_busy_timeout();
      test_reset_mid_run();
      test_halt_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/savestate_sequencer.md
Name: savestate_sequencer

Overview:
- Top-level sequencer for save/load of machine state through the chunked memory streamer.
- Accepts a save or load command with a slot number.
- Halts the emulated core via a halt request/acknowledge handshake, then computes the slot's DDR window and launches the streamer: write_start gathers chunks into memory (save); read_start scatters memory into chunks (load).
- Waits for the streamer to finish, releases the core, and reports a status code.

Parameters:
BASE_ADDR, 32'h3000_0000, DDR byte address of slot 0
SLOT_BITS, 2, width of slot index (2^SLOT_BITS slots)
SLOT_SHIFT, 20, log2 of slot size in bytes (1 MiB slots)
HALT_TIMEOUT, 65535, max cycles waiting for halt_ack
START_TIMEOUT, 15, max cycles waiting for stream busy after a start pulse

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_save  in  1  request save; sampled only when cmd_ready=1
cmd_load  in  1  request load; sampled only when cmd_ready=1
cmd_slot  in  SLOT_BITS  slot index, captured with the command
cmd_ready  out  1  high only in IDLE
done  out  1  one-cycle pulse at end of every accepted command
status  out  2  result of last command: 0 ok, 1 halt timeout, 2 stream no-start; held until next accept
active  out  1  high in every state except IDLE
halt_req  out  1  request core pause
halt_ack  in  1  core paused
ss_start_addr  out  32  streamer start address
ss_length  out  32  streamer window length
ss_read_start  out  1  one-cycle pulse, load
ss_write_start  out  1  one-cycle pulse, save
ss_busy  in  1  streamer busy

Behaviour:
- Reset (async assert, sync release): state IDLE; halt_req, done, ss_read_start, ss_write_start, active = 0; status=0; cmd_ready=1; ss_start_addr=BASE_ADDR; ss_length=1<<SLOT_SHIFT; counters 0.
- Reset mid-operation forces halt_req low immediately, without waiting for the streamer. The streamer has its own reset.
- Address: ss_start_addr = BASE_ADDR + (slot << SLOT_SHIFT), 32-bit, carries beyond bit 31 discarded. ss_length is constant 1<<SLOT_SHIFT. Both are registered at accept and held stable until the next accept.
- IDLE:
  - cmd_save or cmd_load high → capture slot and direction (save wins if both high) → HALT_WAIT.
  - Assert halt_req and clear the counter in the same edge.
- HALT_WAIT:
  - halt_ack=1 → START.
  - Else counter==HALT_TIMEOUT → status=1, deassert halt_req → RELEASE.
  - Else counter+1.
- START: one-cycle pulse on ss_write_start (save) or ss_read_start (load), counter cleared → BUSY_WAIT.
- BUSY_WAIT:
  - ss_busy=1 → RUN.
  - Else counter==START_TIMEOUT → status=2 → RELEASE.
  - Else counter+1.
- RUN: wait for ss_busy=0, with no timeout (stream length is data-dependent) → status=0 → RELEASE.
- RELEASE:
  - halt_req=0; wait for halt_ack=0 → DONE.
  - For the halt-timeout path, halt_ack is already low, so this takes one cycle.
- DONE: done=1 for exactly one cycle → IDLE. cmd_ready rises the cycle after done.
- Commands arriving while cmd_ready=0 are ignored and not queued.
- Latency, save with immediate ack and a 1-cycle streamer busy:
  - accept edge T
  - START at T+1, pulse visible T+2
  - RUN entered when busy is seen
  - done asserted 2 cycles after busy falls, if halt_ack drops within 1 cycle.
- halt_req stays high continuously from accept until RELEASE. It never glitches while the streamer is busy.
- Status register updates only on RUN exit or a timeout. It is not cleared at accept.

Test Plan:
- Save, slot 2, halt_ack 3 cycles later, busy high 40 cycles → ss_start_addr=32'h3020_0000, ss_length=32'h0010_0000, single ss_write_start pulse, status=0, one done pulse, halt_req low before done.
- Load, slot 3 → ss_start_addr=32'h3030_0000, ss_read_start pulses once, ss_write_start never asserted.
- halt_ack never asserted → after 65536 cycles in HALT_WAIT: halt_req drops, no start pulse, status=1, done pulses once.
- halt_ack ok but ss_busy never rises → after 16 cycles in BUSY_WAIT: status=2, halt_req released, done pulses.
- cmd_save and cmd_load both high in IDLE, plus extra commands pulsed during RUN → save executed only, extra commands ignored, exactly one done.
- reset_n low during RUN → halt_req, active and the start pulses go low asynchronously, in the same cycle. After release: IDLE with cmd_ready=1 and status=0.
